// File: rtl/rf_writeback_queue_if.sv
// Writeback queue bus: producer push, register-file write port, decode bypass.
// The slave modport is the queue side; master is the surrounding pipeline.
interface rf_writeback_queue_if #(
  parameter int ADDRESS_PORT_WIDTH = 5,
  parameter int REG_WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                          in_valid;
  logic                          in_ready;
  logic [ADDRESS_PORT_WIDTH-1:0] in_addr;
  logic [REG_WIDTH-1:0]          in_data;
  logic                          wr_stall;
  logic                          RegWrite;
  logic [ADDRESS_PORT_WIDTH-1:0] WriteAddress;
  logic [REG_WIDTH-1:0]          WriteData;
  logic [ADDRESS_PORT_WIDTH-1:0] q_addr;
  logic                          q_hit;
  logic [REG_WIDTH-1:0]          q_data;
  logic [CW-1:0]                 count;

  modport slave (
    input  in_valid, in_addr, in_data,
    input  wr_stall, q_addr,
    output in_ready, RegWrite,
    output WriteAddress, WriteData,
    output q_hit, q_data, count
  );

  modport master (
    output in_valid, in_addr, in_data,
    output wr_stall, q_addr,
    input  in_ready, RegWrite,
    input  WriteAddress, WriteData,
    input  q_hit, q_data, count
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// Register-file writeback FIFO with youngest-match bypass lookup.
// Define WBQ_COALESCE_EN to merge a push into a matching youngest entry.
module rf_writeback_queue #(
  parameter int ADDRESS_PORT_WIDTH = 5,
  parameter int REG_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic CLK,
  input logic Reset,
  rf_writeback_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [ADDRESS_PORT_WIDTH-1:0] addr_t;
  typedef logic [REG_WIDTH-1:0] data_t;

  addr_t addr_q [DEPTH];
  data_t data_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic  empty;
  logic  full;
  logic  push;
  logic  pop;
  logic  merge;
  logic  alloc;
  logic  hit;
  data_t hit_data;

  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign pop   = !empty && !bus.wr_stall;
  assign push  = bus.in_valid && !full;

`ifdef WBQ_COALESCE_EN
  logic [PW-1:0] tail;
  assign tail  = wr_ptr - PW'(1);
  // A lone head leaving this edge cannot absorb the push.
  assign merge = push && !empty
              && bus.in_addr != '0
              && addr_q[tail] == bus.in_addr
              && !(pop && count == CW'(1));
`else
  assign merge = 1'b0;
`endif

  assign alloc = push && bus.in_addr != '0 && !merge;

  assign bus.in_ready     = !full;
  assign bus.RegWrite     = pop;
  assign bus.WriteAddress = empty ? '0 : addr_q[rd_ptr];
  assign bus.WriteData    = empty ? '0 : data_q[rd_ptr];
  assign bus.count        = count;
  assign bus.q_hit        = hit;
  assign bus.q_data       = hit_data;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.q_addr != '0
          && CW'(i) < count
          && addr_q[rd_ptr + PW'(i)] == bus.q_addr) begin
        hit      = 1'b1;
        hit_data = data_q[rd_ptr + PW'(i)];
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (alloc) begin
        addr_q[wr_ptr] <= bus.in_addr;
        data_q[wr_ptr] <= bus.in_data;
        wr_ptr         <= wr_ptr + PW'(1);
      end
`ifdef WBQ_COALESCE_EN
      if (merge) begin
        data_q[tail] <= bus.in_data;
      end
`endif
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({alloc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Randomized and directed bench for rf_writeback_queue.
// Reference model is a queue of pending {addr,data} entries.
module tb_rf_writeback_queue;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic CLK = 1'b0;
  logic Reset;

  rf_writeback_queue_if #(
    .ADDRESS_PORT_WIDTH(AW), .REG_WIDTH(DW), .DEPTH(DEPTH)
  ) bus ();

  rf_writeback_queue #(
    .ADDRESS_PORT_WIDTH(AW), .REG_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors  = 0;
  ent_t mq[$];

  logic          e_rw;
  logic [AW-1:0] e_wa;
  logic [DW-1:0] e_wd;
  int            e_cnt;
  logic          e_rdy;
  logic          e_hit;
  logic [DW-1:0] e_qd;

  task automatic model_expect();
    e_cnt = mq.size();
    e_rdy = mq.size() < DEPTH;
    e_rw  = (mq.size() != 0) && !bus.wr_stall;
    e_wa  = (mq.size() != 0) ? mq[0].a : '0;
    e_wd  = (mq.size() != 0) ? mq[0].d : '0;
    e_hit = 1'b0;
    e_qd  = '0;
    if (bus.q_addr != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].a == bus.q_addr) begin
          e_hit = 1'b1;
          e_qd  = mq[i].d;
          break;
        end
      end
    end
  endtask

  // One clock edge; model mirrors what the edge should do, then #1.
  task automatic tick();
    bit pop_m;
    bit push_m;
    bit merged;
    ent_t e;
    pop_m  = (mq.size() != 0) && !bus.wr_stall;
    push_m = bus.in_valid && (mq.size() < DEPTH);
    e.a = bus.in_addr;
    e.d = bus.in_data;
    @(posedge CLK);
    if (Reset) begin
      mq.delete();
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (push_m && e.a != '0) begin
        merged = 0;
`ifdef WBQ_COALESCE_EN
        if (mq.size() != 0 && mq[mq.size()-1].a == e.a) begin
          mq[mq.size()-1].d = e.d;
          merged = 1;
        end
`endif
        if (!merged) mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.wr_stall = 1'b0;
    for (int k = 0; k < 20 && mq.size() != 0; k++) tick();
    vectors++;
    if (bus.count !== '0) begin
      errors++;
      $display("FAIL drain_count: got %0d expected 0", bus.count);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.wr_stall = 1'b0;
    bus.q_addr   = '0;
    @(posedge CLK);
    #1;
    mq.delete();
    vectors += 5;
    if (bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL reset_regwrite: got %b expected 0", bus.RegWrite);
    end
    if (bus.WriteAddress !== '0) begin
      errors++; $display("FAIL reset_waddr: got %h expected 0", bus.WriteAddress);
    end
    if (bus.WriteData !== '0) begin
      errors++; $display("FAIL reset_wdata: got %h expected 0", bus.WriteData);
    end
    if (bus.count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", bus.count);
    end
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready);
    end
    Reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd1;
    bus.in_data  = 32'hAAAA_BBBB;
    #1;
    vectors++;
    if (bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL first_no_passthru: got %b expected 0", bus.RegWrite);
    end
    tick();
    bus.in_valid = 1'b0;
    #1;
    vectors += 3;
    if (bus.RegWrite !== 1'b1) begin
      errors++; $display("FAIL first_regwrite: got %b expected 1", bus.RegWrite);
    end
    if (bus.WriteAddress !== 5'd1) begin
      errors++; $display("FAIL first_waddr: got %h expected 1", bus.WriteAddress);
    end
    if (bus.WriteData !== 32'hAAAA_BBBB) begin
      errors++; $display("FAIL first_wdata: got %h expected aaaabbbb", bus.WriteData);
    end
    tick();
    vectors++;
    if (bus.count !== '0) begin
      errors++; $display("FAIL first_count: got %0d expected 0", bus.count);
    end
  endtask

  task automatic test_full_stall();
    bus.wr_stall = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.in_addr = AW'(k);
      bus.in_data = 32'h11 * k;
      tick();
    end
    bus.in_addr = 5'd9;
    bus.in_data = 32'h99;
    #1;
    vectors += 2;
    if (bus.count !== 3'd4) begin
      errors++; $display("FAIL full_count: got %0d expected 4", bus.count);
    end
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.wr_stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      vectors += 3;
      if (bus.RegWrite !== 1'b1) begin
        errors++; $display("FAIL drain_rw %0d: got %b expected 1", k, bus.RegWrite);
      end
      if (bus.WriteAddress !== AW'(k)) begin
        errors++; $display("FAIL drain_addr %0d: got %0d expected %0d", k, bus.WriteAddress, k);
      end
      if (bus.WriteData !== 32'h11 * k) begin
        errors++; $display("FAIL drain_data %0d: got %h expected %h", k, bus.WriteData, 32'h11 * k);
      end
      tick();
    end
    vectors += 2;
    if (bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL drain_end_rw: got %b expected 0", bus.RegWrite);
    end
    if (bus.count !== '0) begin
      errors++; $display("FAIL drain_end_count: got %0d expected 0", bus.count);
    end
  endtask

  task automatic test_x0();
    bus.in_valid = 1'b1;
    bus.in_addr  = '0;
    bus.in_data  = 32'hDEAD_BEEF;
    bus.q_addr   = '0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL x0_ready: got %b expected 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors += 3;
      if (bus.count !== '0) begin
        errors++; $display("FAIL x0_count: got %0d expected 0", bus.count);
      end
      if (bus.RegWrite !== 1'b0) begin
        errors++; $display("FAIL x0_rw: got %b expected 0", bus.RegWrite);
      end
      if (bus.q_hit !== 1'b0) begin
        errors++; $display("FAIL x0_qhit: got %b expected 0", bus.q_hit);
      end
      tick();
    end
  endtask

  task automatic test_same_addr();
    logic [DW-1:0] exp_seq[$];
    int exp_cnt;
`ifdef WBQ_COALESCE_EN
    exp_seq = '{32'h2};
    exp_cnt = 1;
`else
    exp_seq = '{32'h1, 32'h2};
    exp_cnt = 2;
`endif
    bus.wr_stall = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd5;
    bus.in_data  = 32'h1;
    tick();
    bus.in_data  = 32'h2;
    tick();
    bus.in_valid = 1'b0;
    bus.q_addr   = 5'd5;
    #1;
    vectors += 3;
    if (bus.q_hit !== 1'b1) begin
      errors++; $display("FAIL same_qhit: got %b expected 1", bus.q_hit);
    end
    if (bus.q_data !== 32'h2) begin
      errors++; $display("FAIL same_qdata: got %h expected 2", bus.q_data);
    end
    if (int'(bus.count) != exp_cnt) begin
      errors++; $display("FAIL same_count: got %0d expected %0d", bus.count, exp_cnt);
    end
    bus.wr_stall = 1'b0;
    foreach (exp_seq[k]) begin
      #1;
      vectors += 2;
      if (bus.RegWrite !== 1'b1) begin
        errors++; $display("FAIL same_rw %0d: got %b expected 1", k, bus.RegWrite);
      end
      if (bus.WriteData !== exp_seq[k]) begin
        errors++; $display("FAIL same_data %0d: got %h expected %h", k, bus.WriteData, exp_seq[k]);
      end
      tick();
    end
    vectors++;
    if (bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL same_end_rw: got %b expected 0", bus.RegWrite);
    end
  endtask

  task automatic test_wrap();
    bus.wr_stall = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr = 5'd6; bus.in_data = $urandom; tick();
    bus.in_addr = 5'd7; bus.in_data = $urandom; tick();
    bus.wr_stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = i < 10;
      bus.in_addr  = (i % 2) ? 5'd6 : 5'd7;
      bus.in_data  = $urandom;
      bus.q_addr   = (i % 2) ? 5'd7 : 5'd6;
      #1;
      model_expect();
      vectors += 5;
      if (bus.RegWrite !== e_rw) begin
        errors++; $display("FAIL wrap_rw %0d: got %b expected %b", i, bus.RegWrite, e_rw);
      end
      if (bus.WriteAddress !== e_wa) begin
        errors++; $display("FAIL wrap_addr %0d: got %h expected %h", i, bus.WriteAddress, e_wa);
      end
      if (bus.WriteData !== e_wd) begin
        errors++; $display("FAIL wrap_data %0d: got %h expected %h", i, bus.WriteData, e_wd);
      end
      if (bus.q_hit !== e_hit) begin
        errors++; $display("FAIL wrap_qhit %0d: got %b expected %b", i, bus.q_hit, e_hit);
      end
      if (bus.q_data !== e_qd) begin
        errors++; $display("FAIL wrap_qdata %0d: got %h expected %h", i, bus.q_data, e_qd);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bus.wr_stall = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_addr = AW'(10 + k);
      bus.in_data = $urandom;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.wr_stall = 1'b0;
    #1;
    vectors += 2;
    if (bus.RegWrite !== 1'b1) begin
      errors++; $display("FAIL rmid_pre_rw: got %b expected 1", bus.RegWrite);
    end
    if (bus.count !== 3'd3) begin
      errors++; $display("FAIL rmid_pre_count: got %0d expected 3", bus.count);
    end
    Reset = 1'b1;
    #1;
    vectors += 2;
    if (bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL rmid_rw: got %b expected 0", bus.RegWrite);
    end
    if (bus.count !== '0) begin
      errors++; $display("FAIL rmid_count: got %0d expected 0", bus.count);
    end
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors += 2;
      if (bus.RegWrite !== 1'b0) begin
        errors++; $display("FAIL rmid_after_rw %0d: got %b expected 0", k, bus.RegWrite);
      end
      if (bus.WriteAddress !== '0) begin
        errors++; $display("FAIL rmid_after_addr %0d: got %h expected 0", k, bus.WriteAddress);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = $urandom_range(0, 9) < 7;
      bus.in_addr  = AW'($urandom_range(0, 7));
      bus.in_data  = $urandom;
      bus.wr_stall = $urandom_range(0, 9) < 4;
      bus.q_addr   = AW'($urandom_range(0, 7));
      #1;
      model_expect();
      vectors += 7;
      if (bus.RegWrite !== e_rw) begin
        errors++; $display("FAIL rnd_rw %0d: got %b expected %b", i, bus.RegWrite, e_rw);
      end
      if (bus.WriteAddress !== e_wa) begin
        errors++; $display("FAIL rnd_addr %0d: got %h expected %h", i, bus.WriteAddress, e_wa);
      end
      if (bus.WriteData !== e_wd) begin
        errors++; $display("FAIL rnd_data %0d: got %h expected %h", i, bus.WriteData, e_wd);
      end
      if (int'(bus.count) != e_cnt) begin
        errors++; $display("FAIL rnd_count %0d: got %0d expected %0d", i, bus.count, e_cnt);
      end
      if (bus.in_ready !== e_rdy) begin
        errors++; $display("FAIL rnd_ready %0d: got %b expected %b", i, bus.in_ready, e_rdy);
      end
      if (bus.q_hit !== e_hit) begin
        errors++; $display("FAIL rnd_qhit %0d: got %b expected %b", i, bus.q_hit, e_hit);
      end
      if (bus.q_data !== e_qd) begin
        errors++; $display("FAIL rnd_qdata %0d: got %h expected %h", i, bus.q_data, e_qd);
      end
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_full_stall();
    test_x0();
    test_same_addr();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
